// File: rtl/sram_arbiter.sv
// Arbitrates one single-port 1-cycle SRAM between fetch (read-only) and data (read/write); data has priority, with starvation relief for fetch.
// Latency: grant is combinational in the issue cycle, and data_ok/rdata follow exactly 1 cycle later. Fully pipelined, in order.
// Backpressure: none on data_ok. A losing requester sees addr_ok=0 and holds req. Optional counters: ARB_PERF_CNT_EN.
module sram_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_inst_grants,
    output logic [31:0] perf_data_grants,
    output logic [31:0] perf_conflicts
`endif
);

    localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

    logic             grant_i;
    logic             grant_d;
    logic             force_inst;
    logic             resp_v_q,     resp_v_d;
    logic             resp_own_q,   resp_own_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Fixed priority to data, except once fetch has waited STARVE_MAX data grants.
    always_comb begin
        force_inst = inst_req && data_req && (starve_cnt_q == STARVE_MAX_C);
        grant_d    = !reset && data_req && !force_inst;
        grant_i    = !reset && inst_req && !grant_d;
    end

    // Steer the granted side onto the SRAM port; everything reads as zero with no grant.
    always_comb begin
        inst_addr_ok = grant_i;
        data_addr_ok = grant_d;
        sram_en      = grant_i | grant_d;
        sram_wen     = 4'h0;
        sram_addr    = 32'h0;
        sram_wdata   = 32'h0;
        if (grant_d) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            sram_wen   = data_wr ? data_wstrb : 4'h0;
        end else if (grant_i) begin
            sram_addr  = inst_addr;
        end
    end

    // Response tag tracks the owner of last cycle's access; starvation counter counts data wins over a waiting fetch.
    always_comb begin
        resp_v_d     = grant_i | grant_d;
        resp_own_d   = grant_d;
        starve_cnt_d = starve_cnt_q;
        if (grant_d && inst_req) begin
            if (starve_cnt_q != STARVE_MAX_C) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end else if (grant_i || !inst_req) begin
            starve_cnt_d = '0;
        end
    end

    // State registers with synchronous reset; an in-flight response is discarded by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_v_q     <= 1'b0;
            resp_own_q   <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            resp_v_q     <= resp_v_d;
            resp_own_q   <= resp_own_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Response routing; gated by reset so a transaction issued just before reset never reports.
    always_comb begin
        inst_data_ok = resp_v_q && !resp_own_q && !reset;
        data_data_ok = resp_v_q &&  resp_own_q && !reset;
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_inst_grants_q, perf_inst_grants_d;
    logic [31:0] perf_data_grants_q, perf_data_grants_d;
    logic [31:0] perf_conflicts_q,   perf_conflicts_d;

    // Free-running event counters that wrap naturally at 2^32.
    always_comb begin
        perf_inst_grants_d = perf_inst_grants_q + {31'h0, grant_i};
        perf_data_grants_d = perf_data_grants_q + {31'h0, grant_d};
        perf_conflicts_d   = perf_conflicts_q   + {31'h0, (inst_req && data_req)};
    end

    // Counter registers cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_inst_grants_q <= 32'h0;
            perf_data_grants_q <= 32'h0;
            perf_conflicts_q   <= 32'h0;
        end else begin
            perf_inst_grants_q <= perf_inst_grants_d;
            perf_data_grants_q <= perf_data_grants_d;
            perf_conflicts_q   <= perf_conflicts_d;
        end
    end

    assign perf_inst_grants = perf_inst_grants_q;
    assign perf_data_grants = perf_data_grants_q;
    assign perf_conflicts   = perf_conflicts_q;
`endif

endmodule
